// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch requester (I,
// read-only) and the load/store requester (D, read/write). D has fixed
// priority. A consecutive-D-grant counter lets a waiting fetch through after
// MAX_D_STREAK D grants. A fetch response hit by a flush is swallowed.
//
// Handshake (identical on I, D and mem): the requester raises enable together
// with its address/data and holds them all stable until the cycle in which
// ready is high; that cycle completes the transfer. The requester may drop or
// change its request at the following edge. Ready is a one-cycle pulse and is
// never raised without a matching request.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_enable,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_enable,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [1:0]          dbg_state_o
);

  localparam int SW = DATA_W / 8;
  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]       mem_wstrb_q, mem_wstrb_d;
  logic                drop_q, drop_d;
  logic [3:0]          d_streak_q, d_streak_d;

  logic                grant_d;
  logic                grant_i;

  // D wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
  assign grant_d = d_enable && !(i_enable && (d_streak_q == MAX_S));
  assign grant_i = i_enable && !grant_d;

  // Next-state, memory-request capture, flush tracking and starvation counter.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    drop_d       = drop_q;
    d_streak_d   = d_streak_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = BUSY_D;
          mem_enable_d = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_wstrb_d  = d_we ? d_wstrb : '0;
          if (i_enable) begin
            if (d_streak_q != MAX_S) d_streak_d = d_streak_q + 4'd1;
          end else begin
            d_streak_d = '0;
          end
        end else if (grant_i) begin
          state_d      = BUSY_I;
          mem_enable_d = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = i_addr;
          mem_wdata_d  = '0;
          mem_wstrb_d  = '0;
          drop_d       = i_flush;
          d_streak_d   = '0;
        end else begin
          d_streak_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d      = IDLE;
          mem_enable_d = 1'b0;
          drop_d       = 1'b0;
        end else begin
          drop_d = drop_q | i_flush;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d      = IDLE;
          mem_enable_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        mem_enable_d = 1'b0;
        drop_d       = 1'b0;
      end
    endcase
  end

  // State and registered memory request; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      drop_q       <= 1'b0;
      d_streak_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      drop_q       <= drop_d;
      d_streak_q   <= d_streak_d;
    end
  end

  // Responses pass straight through in the mem_ready cycle; a flushed fetch is silenced.
  assign i_ready     = (state_q == BUSY_I) && mem_ready && !drop_q && !i_flush;
  assign d_ready     = (state_q == BUSY_D) && mem_ready;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign mem_enable  = mem_enable_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
